id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage directly upstream of the ALU.
- Captures decoded operands and control from decode, then drives the ALU inputs `a`, `b` and `alucontrol`.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- Handles stall (hold), flush and bubble insertion.

Parameters:
- XLEN, 32, datapath width
- REGW, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  downstream hold; register keeps contents
- flush  input  1  kill EX-stage contents (branch taken)
- in_valid  input  1  decode output valid
- in_rs1, in_rs2  input  REGW  source register indices
- in_rd  input  REGW  destination index
- in_rs1_val, in_rs2_val  input  XLEN  register file read data
- in_imm  input  XLEN  sign-extended immediate
- in_alusrc  input  1  1 = ALU b takes the immediate
- in_alucontrol  input  3  ALU op code
- in_regwrite, in_memread, in_memwrite  input  1  control bits
- exmem_regwrite  input  1  EX/MEM writes a register
- exmem_rd  input  REGW  EX/MEM destination index
- exmem_result  input  XLEN  EX/MEM ALU result
- memwb_regwrite  input  1  MEM/WB writes a register
- memwb_rd  input  REGW  MEM/WB destination index
- memwb_result  input  XLEN  MEM/WB writeback value
- alu_a, alu_b  output  XLEN  ALU operands
- alucontrol  output  3  ALU op
- store_data  output  XLEN  forwarded rs2 for stores
- out_valid  output  1  EX stage holds a live instruction
- out_rd  output  REGW  registered destination index
- out_regwrite, out_memread, out_memwrite  output  1  registered control
- load_use_hazard  output  1  upstream must stall IF/ID this cycle

Behaviour:
- **Register update priority** (all at posedge clk), highest first:
  - reset: all fields 0, out_valid = 0.
  - flush: bubble (valid and all control bits 0; data don't-care, driven 0).
  - stall: hold.
  - load_use_hazard: bubble.
  - otherwise: load the in_* fields, with valid = in_valid.
- **Control gating:** a bubble or !in_valid forces regwrite, memread and memwrite to 0. Invalid entries never write.
- **Reset outputs:** alu_a = alu_b = store_data = 0, alucontrol = 3'b000, out_valid = 0, out_rd = 0, all control outputs 0, load_use_hazard = 0.
- **Forwarding** (combinational on the registered rs1/rs2 and their values), per operand:
  - EX/MEM hit, if exmem_regwrite and exmem_rd != 0 and exmem_rd == rs: use exmem_result.
  - Else MEM/WB hit, same rule with the memwb_* signals: use memwb_result.
  - Else the registered value.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded; rs == 0 always yields the registered value.
- **Operand outputs:**
  - alu_a = fwd_rs1.
  - alu_b = in_alusrc_q ? imm_q : fwd_rs2.
  - store_data = fwd_rs2, independent of alusrc.
- **Stall refresh:** while stall=1 and not flush/reset, a MEM/WB hit on a held rs (rs != 0) overwrites the held rsN_val with memwb_result. This prevents a stale value after the writer retires during the hold. The held value is not refreshed from EX/MEM.
- **Load-use hazard** (combinational): load_use_hazard = out_valid & out_memread & (out_rd != 0) & in_valid & ((out_rd == in_rs1) | (out_rd == in_rs2)).
  - Asserted for exactly one cycle per load-use pair, unless stall extends it.
  - The bubble resolves the hazard; the dependent instruction is then forwarded from MEM/WB on the following cycles.
- **Latency:** 1 cycle from the in_* inputs to the EX-stage outputs. Forwarding adds no cycle.
- **Simultaneous events:**
  - flush with stall: flush wins.
  - flush with hazard: flush wins, output is a bubble.
  - Reset mid-operation: everything is dropped next edge; no partial state survives.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op constants: ALU_ADD = 000, SUB = 001, SLL = 010, SLT = 011, XOR = 100, SRL = 101, OR = 110, AND = 111.
  - Forward-select codes (2-bit): FWD_REG = 00, FWD_EXMEM = 01, FWD_MEMWB = 10.
  - XLEN and REGW.
- One sub-module, forward_unit: pure combinational, used twice (rs1 and rs2). It takes rs, the two (regwrite, rd) pairs and returns the select code. id_ex_stage contains the register, the muxes and hazard detection.

Test Plan:
- Basic load: in_valid=1, rs1_val=5, rs2_val=7, alusrc=0, alucontrol=000, no forwarding → next cycle alu_a=5, alu_b=7, alucontrol=000, out_valid=1.
- Forward priority: registered rs1=3; exmem_regwrite=1, exmem_rd=3, exmem_result=0x11; memwb_regwrite=1, memwb_rd=3, memwb_result=0x22 → alu_a=0x11. Drop exmem_regwrite → alu_a=0x22. Set rs1=0 with rd=0 on both → alu_a=registered value.
- Immediate and store: alusrc=1, imm=0xFFFFFFFC, rs2=4, exmem_rd=4, exmem_result=0x99 → alu_b=0xFFFFFFFC, store_data=0x99.
- Load-use: EX holds memread=1, rd=6, out_valid=1; decode presents in_rs2=6 → load_use_hazard=1. Next cycle out_valid=0, all controls 0. Same instruction presented again → loads normally, and 1 cycle later operand 6 forwards from MEM/WB.
- Stall refresh: hold a valid entry with rs1=8, rs1_val=1, stall=1; pulse memwb_regwrite=1, rd=8, result=0x55, then drop it → alu_a=0x55 after release. Outputs are otherwise unchanged during the stall.
- Flush and reset: flush=1 together with stall=1 and hazard=1 → bubble next cycle. reset=1 mid-stream → all outputs 0 next edge, load_use_hazard=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath widths, ALU op codes and forwarding select codes for the
// integer pipeline.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_SLT = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Picks the freshest source for one EX-stage operand; EX/MEM beats MEM/WB,
// and x0 never matches because a zero destination is ignored.
module forward_unit
    import cpu_pkg::*;
#(
    parameter int REGW = cpu_pkg::REGW
) (
    input  logic [REGW-1:0] rs,
    input  logic            exmem_regwrite,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            memwb_regwrite,
    input  logic [REGW-1:0] memwb_rd,
    output fwd_sel_t        sel
);

    always_comb begin
        sel = FWD_REG;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU, load-use
// hazard detection, and stall/flush/bubble handling.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int REGW = cpu_pkg::REGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [REGW-1:0] in_rd,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_alusrc,
    input  logic [2:0]      in_alucontrol,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic            exmem_regwrite,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alucontrol,
    output logic [XLEN-1:0] store_data,
    output logic            out_valid,
    output logic [REGW-1:0] out_rd,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic            load_use_hazard
);

    logic            valid_q, valid_d;
    logic [REGW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
    logic            alusrc_q, alusrc_d;
    logic [2:0]      alucontrol_q, alucontrol_d;
    logic            regwrite_q, regwrite_d;
    logic            memread_q, memread_d;
    logic            memwrite_q, memwrite_d;

    fwd_sel_t        sel_rs1, sel_rs2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    assign load_use_hazard = valid_q & memread_q & (rd_q != '0) & in_valid
                           & ((rd_q == in_rs1) | (rd_q == in_rs2));

    always_comb begin
        valid_d      = valid_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        rs1_val_d    = rs1_val_q;
        rs2_val_d    = rs2_val_q;
        imm_d        = imm_q;
        alusrc_d     = alusrc_q;
        alucontrol_d = alucontrol_q;
        regwrite_d   = regwrite_q;
        memread_d    = memread_q;
        memwrite_d   = memwrite_q;
        if (flush || (!stall && load_use_hazard)) begin
            valid_d      = 1'b0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            rs1_val_d    = '0;
            rs2_val_d    = '0;
            imm_d        = '0;
            alusrc_d     = 1'b0;
            alucontrol_d = 3'b000;
            regwrite_d   = 1'b0;
            memread_d    = 1'b0;
            memwrite_d   = 1'b0;
        end else if (stall) begin
            // A writer retiring from MEM/WB during the hold would otherwise
            // leave a stale operand once it leaves the forwarding window.
            if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs1_q)) begin
                rs1_val_d = memwb_result;
            end
            if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs2_q)) begin
                rs2_val_d = memwb_result;
            end
        end else begin
            valid_d      = in_valid;
            rs1_d        = in_rs1;
            rs2_d        = in_rs2;
            rd_d         = in_rd;
            rs1_val_d    = in_rs1_val;
            rs2_val_d    = in_rs2_val;
            imm_d        = in_imm;
            alusrc_d     = in_alusrc;
            alucontrol_d = in_alucontrol;
            regwrite_d   = in_valid & in_regwrite;
            memread_d    = in_valid & in_memread;
            memwrite_d   = in_valid & in_memwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            rs1_val_q    <= '0;
            rs2_val_q    <= '0;
            imm_q        <= '0;
            alusrc_q     <= 1'b0;
            alucontrol_q <= 3'b000;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            rs1_val_q    <= rs1_val_d;
            rs2_val_q    <= rs2_val_d;
            imm_q        <= imm_d;
            alusrc_q     <= alusrc_d;
            alucontrol_q <= alucontrol_d;
            regwrite_q   <= regwrite_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
        end
    end

    forward_unit #(.REGW(REGW)) u_fwd_rs1 (
        .rs             (rs1_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .sel            (sel_rs1)
    );

    forward_unit #(.REGW(REGW)) u_fwd_rs2 (
        .rs             (rs2_q),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .sel            (sel_rs2)
    );

    always_comb begin
        case (sel_rs1)
            FWD_EXMEM: fwd_rs1 = exmem_result;
            FWD_MEMWB: fwd_rs1 = memwb_result;
            default:   fwd_rs1 = rs1_val_q;
        endcase
        case (sel_rs2)
            FWD_EXMEM: fwd_rs2 = exmem_result;
            FWD_MEMWB: fwd_rs2 = memwb_result;
            default:   fwd_rs2 = rs2_val_q;
        endcase
    end

    assign alu_a        = fwd_rs1;
    assign alu_b        = alusrc_q ? imm_q : fwd_rs2;
    assign store_data   = fwd_rs2;
    assign alucontrol   = alucontrol_q;
    assign out_valid    = valid_q;
    assign out_rd       = rd_q;
    assign out_regwrite = regwrite_q;
    assign out_memread  = memread_q;
    assign out_memwrite = memwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage, checked against a
// behavioural model of the EX-stage entry and its forwarding rules.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_alusrc;
    logic [2:0]  in_alucontrol;
    logic        in_regwrite, in_memread, in_memwrite;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, store_data;
    logic [2:0]  alucontrol;
    logic        out_valid, out_regwrite, out_memread, out_memwrite, load_use_hazard;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic        alusrc;
        logic [2:0]  op;
        logic        rw, mr, mw;
    } ent_t;
    ent_t m;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_alusrc(in_alusrc), .in_alucontrol(in_alucontrol),
        .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alucontrol(alucontrol), .store_data(store_data),
        .out_valid(out_valid), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .out_memread(out_memread), .out_memwrite(out_memwrite),
        .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value an instruction actually sees for register rs whose file read was rv.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rv);
        if (rs != 0 && exmem_regwrite && exmem_rd == rs) return exmem_result;
        if (rs != 0 && memwb_regwrite && memwb_rd == rs) return memwb_result;
        return rv;
    endfunction

    function automatic logic model_hazard();
        return m.v && m.mr && m.rd != 0 && in_valid && (m.rd == in_rs1 || m.rd == in_rs2);
    endfunction

    task automatic step();
        ent_t nx;
        logic haz;
        @(negedge clk);
        haz = model_hazard();
        chk("alu_a", alu_a, fwd(m.rs1, m.v1));
        chk("alu_b", alu_b, m.alusrc ? m.imm : fwd(m.rs2, m.v2));
        chk("store_data", store_data, fwd(m.rs2, m.v2));
        chk("alucontrol", 32'(alucontrol), 32'(m.op));
        chk("out_valid", 32'(out_valid), 32'(m.v));
        chk("out_rd", 32'(out_rd), 32'(m.rd));
        chk("out_regwrite", 32'(out_regwrite), 32'(m.rw));
        chk("out_memread", 32'(out_memread), 32'(m.mr));
        chk("out_memwrite", 32'(out_memwrite), 32'(m.mw));
        chk("load_use_hazard", 32'(load_use_hazard), 32'(haz));
        nx = m;
        if (reset) begin
            nx = '0;
        end else if (flush) begin
            nx = '0;
        end else if (stall) begin
            if (m.rs1 != 0 && memwb_regwrite && memwb_rd == m.rs1) nx.v1 = memwb_result;
            if (m.rs2 != 0 && memwb_regwrite && memwb_rd == m.rs2) nx.v2 = memwb_result;
        end else if (haz) begin
            nx = '0;
        end else begin
            nx.v = in_valid;    nx.rs1 = in_rs1;    nx.rs2 = in_rs2;   nx.rd = in_rd;
            nx.v1 = in_rs1_val; nx.v2 = in_rs2_val; nx.imm = in_imm;
            nx.alusrc = in_alusrc; nx.op = in_alucontrol;
            nx.rw = in_valid && in_regwrite;
            nx.mr = in_valid && in_memread;
            nx.mw = in_valid && in_memwrite;
        end
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] imm, input logic alusrc, input logic [2:0] op,
                           input logic rw, input logic mr, input logic mw);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm;
        in_alusrc = alusrc; in_alucontrol = op;
        in_regwrite = rw; in_memread = mr; in_memwrite = mw;
    endtask

    task automatic set_exmem(input logic w, input logic [4:0] rd, input logic [31:0] r);
        exmem_regwrite = w; exmem_rd = rd; exmem_result = r;
    endtask

    task automatic set_memwb(input logic w, input logic [4:0] rd, input logic [31:0] r);
        memwb_regwrite = w; memwb_rd = rd; memwb_result = r;
    endtask

    initial begin
        m = '0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        set_exmem(0, 0, 0);
        set_memwb(0, 0, 0);
        @(posedge clk); #1;
        m = '0;
        step();
        reset = 1'b0;
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_hazard", 32'(load_use_hazard), 32'h0);

        // basic load
        set_dec(1, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'h0, 0, 3'b000, 1, 0, 0);
        step();
        chk("basic_alu_a", alu_a, 32'd5);
        chk("basic_alu_b", alu_b, 32'd7);
        chk("basic_out_valid", 32'(out_valid), 32'd1);
        chk("basic_alucontrol", 32'(alucontrol), 32'd0);

        // forward priority
        set_dec(1, 5'd3, 5'd2, 5'd10, 32'h33, 32'h2, 32'h0, 0, 3'b001, 1, 0, 0);
        step();
        in_valid = 0;
        set_exmem(1, 5'd3, 32'h11);
        set_memwb(1, 5'd3, 32'h22);
        #1 chk("fwd_exmem_prio", alu_a, 32'h11);
        exmem_regwrite = 0;
        #1 chk("fwd_memwb", alu_a, 32'h22);
        set_dec(1, 5'd0, 5'd2, 5'd10, 32'h44, 32'h2, 32'h0, 0, 3'b001, 1, 0, 0);
        set_exmem(0, 0, 0);
        set_memwb(0, 0, 0);
        step();
        set_exmem(1, 5'd0, 32'hAAAA);
        set_memwb(1, 5'd0, 32'hBBBB);
        #1 chk("fwd_x0_never", alu_a, 32'h44);
        step();

        // immediate and store data
        set_exmem(0, 0, 0);
        set_memwb(0, 0, 0);
        set_dec(1, 5'd1, 5'd4, 5'd0, 32'h1, 32'h40, 32'hFFFFFFFC, 1, 3'b000, 0, 0, 1);
        step();
        set_exmem(1, 5'd4, 32'h99);
        #1 chk("imm_alu_b", alu_b, 32'hFFFFFFFC);
        chk("store_fwd", store_data, 32'h99);
        step();

        // load-use hazard
        set_exmem(0, 0, 0);
        set_dec(1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 1, 3'b000, 1, 1, 0);
        step();
        set_dec(1, 5'd1, 5'd6, 5'd7, 32'h5, 32'h60, 32'h0, 0, 3'b000, 1, 0, 0);
        #1 chk("lu_hazard", 32'(load_use_hazard), 32'd1);
        step();
        chk("lu_bubble_valid", 32'(out_valid), 32'd0);
        chk("lu_bubble_rw", 32'(out_regwrite), 32'd0);
        chk("lu_hazard_clear", 32'(load_use_hazard), 32'd0);
        step();
        set_memwb(1, 5'd6, 32'h66);
        #1 chk("lu_fwd_memwb", store_data, 32'h66);
        chk("lu_out_valid", 32'(out_valid), 32'd1);
        step();

        // stall refresh
        set_memwb(0, 0, 0);
        set_dec(1, 5'd8, 5'd0, 5'd3, 32'h1, 32'h0, 32'h0, 0, 3'b010, 1, 0, 0);
        step();
        stall = 1;
        set_dec(1, 5'd2, 5'd3, 5'd4, 32'hDEAD, 32'hBEEF, 32'h0, 0, 3'b111, 1, 0, 0);
        set_memwb(1, 5'd8, 32'h55);
        step();
        set_memwb(0, 0, 0);
        step();
        chk("stall_out_rd", 32'(out_rd), 32'd3);
        chk("stall_alucontrol", 32'(alucontrol), 32'd2);
        stall = 0;
        #1 chk("stall_refresh", alu_a, 32'h55);
        step();

        // flush beats stall and hazard
        set_dec(1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 0, 3'b000, 1, 1, 0);
        step();
        set_dec(1, 5'd6, 5'd0, 5'd7, 32'h5, 32'h0, 32'h0, 0, 3'b000, 1, 0, 0);
        stall = 1; flush = 1;
        #1 chk("flush_hazard_seen", 32'(load_use_hazard), 32'd1);
        step();
        stall = 0; flush = 0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_memread", 32'(out_memread), 32'd0);

        // reset mid-stream
        set_dec(1, 5'd5, 5'd6, 5'd7, 32'h123, 32'h456, 32'h789, 0, 3'b100, 1, 1, 1);
        step();
        reset = 1;
        set_exmem(1, 5'd5, 32'hCAFE);
        step();
        chk("midrst_alu_a", alu_a, 32'h0);
        chk("midrst_store", store_data, 32'h0);
        chk("midrst_out_rd", 32'(out_rd), 32'h0);
        chk("midrst_hazard", 32'(load_use_hazard), 32'h0);
        reset = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(63) == 0);
            stall = ($urandom_range(7) == 0);
            flush = ($urandom_range(15) == 0);
            set_dec($urandom_range(3) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
                    5'($urandom_range(7)), $urandom, $urandom, $urandom,
                    1'($urandom_range(1)), 3'($urandom_range(7)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            set_exmem(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
            set_memwb(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
